// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue.
// Issues sequential fetch addresses to a synchronous-read instruction memory.
// Returned words are buffered with their PC in a DEPTH-entry FIFO feeding ID.
// A taken branch redirects the fetch PC and discards queued and in-flight words.
//
// Ports:
//   clk, rst (sync, active-low)      clock and reset
//   freeze                           ID stall; head is not consumed while high
//   Branch_Taken, Branch_Address     redirect/flush request and target
//   imem_req, imem_addr              memory read request and address (fetch PC)
//   imem_rdata                       read data, valid the cycle after a request
//   if_valid, pc, instruction        FIFO head presented to ID
//   fifo_count                       current FIFO occupancy
module if_prefetch_stage #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter int unsigned            DEPTH       = 4,
    parameter int unsigned            PC_STEP     = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      Branch_Taken,
    input  logic [ADDR_WIDTH-1:0]     Branch_Address,
    output logic                      imem_req,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0]    imem_rdata,
    output logic                      if_valid,
    output logic [ADDR_WIDTH-1:0]     pc,
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // One extra bit so count + inflight never wraps in the credit sum.
    localparam int unsigned UW = CW + 1;

    logic [ADDR_WIDTH-1:0]  r_fpc;
    logic [ADDR_WIDTH-1:0]  r_ipc;
    logic                   r_inflight;
    logic [ADDR_WIDTH-1:0]  r_pc_mem  [DEPTH];
    logic [INSTR_WIDTH-1:0] r_ins_mem [DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;

    logic                   w_pop;
    logic                   w_push;
    logic [UW-1:0]          w_used;

    // Head is consumed whenever it is valid and ID is not stalled.
    assign w_pop  = if_valid & ~freeze;
    // A returning word is kept only when no flush or reset lands on it.
    assign w_push = rst & ~Branch_Taken & r_inflight;

    // Credit check: slots already owed (queued + in flight) less the slot
    // freed by this cycle's pop must leave room for one more response.
    assign w_used   = UW'(r_count) + UW'(r_inflight) - UW'(w_pop);
    assign imem_req = rst & ~Branch_Taken & (w_used < UW'(DEPTH));

    assign imem_addr   = r_fpc;
    assign if_valid    = (r_count != '0);
    assign pc          = r_pc_mem[r_rptr];
    assign instruction = r_ins_mem[r_rptr];
    assign fifo_count  = r_count;

    // Fetch PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fpc      <= RESET_PC;
            r_ipc      <= RESET_PC;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (Branch_Taken) begin
            // Branch wins over any pop, freeze or arriving response.
            r_fpc      <= Branch_Address;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_fpc <= r_fpc + ADDR_WIDTH'(PC_STEP);
                r_ipc <= r_fpc;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage; contents are meaningless while the slot is not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]  <= r_ipc;
            r_ins_mem[r_wptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomised and directed bench for if_prefetch_stage. A queue-based model of
// the fetch stream (expected FIFO contents plus the pending fetch) predicts
// every output cycle by cycle.
module tb_if_prefetch_stage;

    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        freeze;
    logic        Branch_Taken;
    logic [31:0] Branch_Address;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] dut_pc;
    logic [31:0] dut_instr;
    logic [2:0]  fifo_count;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [2:0]  w_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_ipc;
    logic [31:0] m_fpc;

    if_prefetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH),
                        .PC_STEP(4), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .pc(dut_pc), .instruction(dut_instr),
        .fifo_count(fifo_count)
    );

    if_prefetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH),
                        .PC_STEP(4), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst(rst), .freeze(freeze),
        .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .if_valid(w_valid), .pc(w_pc), .instruction(w_instr),
        .fifo_count(w_count)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        imem_rdata <= memf(imem_addr);
        w_rdata    <= memf(w_addr);
    end

    function automatic bit exp_req();
        int pop;
        int used;
        pop  = (mq.size() != 0 && !freeze) ? 1 : 0;
        used = mq.size() + int'(m_pend) - pop;
        return rst && !Branch_Taken && (used < int'(DEPTH));
    endfunction

    function automatic logic [100:0] exp_vec();
        bit v;
        v = (mq.size() != 0);
        return {v, 3'(mq.size()), exp_req(), m_fpc,
                v ? mq[0] : 32'h0, v ? memf(mq[0]) : 32'h0};
    endfunction

    function automatic logic [100:0] obs_vec();
        return {if_valid, fifo_count, imem_req, imem_addr,
                if_valid ? dut_pc : 32'h0, if_valid ? dut_instr : 32'h0};
    endfunction

    // Advance the model by one clock using the current inputs, then the clock.
    task automatic tick();
        bit req;
        req = exp_req();
        if (!rst) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = RST_PC;
        end else if (Branch_Taken) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = Branch_Address;
        end else begin
            if (mq.size() != 0 && !freeze) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_ipc);
            m_pend = req;
            if (req) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; Branch_Taken = 1'b0; Branch_Address = '0;
        mq.delete(); m_pend = 1'b0; m_fpc = RST_PC; m_ipc = RST_PC;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({if_valid, fifo_count, imem_req, imem_addr} !== {1'b0, 3'd0, 1'b0, RST_PC}) begin
                errors++;
                $display("FAIL reset cyc %0d: got v=%b cnt=%0d req=%b addr=%h, want 0/0/0/%h",
                         i, if_valid, fifo_count, imem_req, imem_addr, RST_PC);
            end
            tick();
        end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_freeze_fill();
        for (int i = 0; i < 14; i++) begin
            freeze = (i < 8);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL freeze_fill cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    // Hold freeze until three entries are queued with one fetch in flight.
    task automatic fill_to_three(input string tag);
        bit hit = 1'b0;
        freeze = 1'b1;
        for (int i = 0; i < 12 && !hit; i++) begin
            @(negedge clk);
            if (mq.size() == 3 && m_pend) begin
                hit = 1'b1;
            end else begin
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL %s_fill cyc %0d: got %h want %h", tag, i, obs_vec(), exp_vec());
                end
                tick();
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s_setup: got no 3-queued+inflight state, want one within 12 cycles", tag);
        end
    endtask

    task automatic test_branch_flush();
        fill_to_three("branch");
        Branch_Taken = 1'b1; Branch_Address = 32'h0000_0100;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin Branch_Taken = 1'b0; freeze = 1'b0; end
            if (i > 0) @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL branch_flush cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 3) begin
                checks++;
                if ({if_valid, dut_pc} !== {1'b1, 32'h0000_0100}) begin
                    errors++;
                    $display("FAIL branch_target: got v=%b pc=%h, want 1 00000100", if_valid, dut_pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch_pop();
        logic [31:0] tgt;
        freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            for (int i = 0; i < 8; i++) begin
                Branch_Taken   = (i == 3);
                Branch_Address = tgt;
                @(negedge clk);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL branch_pop %0d cyc %0d: got %h want %h", k, i, obs_vec(), exp_vec());
                end
                tick();
            end
        end
        Branch_Taken = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill_to_three("rst_mid");
        for (int i = 0; i < 8; i++) begin
            rst    = (i != 0);
            freeze = (i == 0);
            if (i > 0) @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 63) != 0);
            freeze         = $urandom_range(0, 1) != 0;
            Branch_Taken   = ($urandom_range(0, 15) == 0);
            Branch_Address = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                         : ($urandom & 32'hFFFF_FFFC);
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        rst = 1'b1; freeze = 1'b0; Branch_Taken = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        rst = 1'b0; freeze = 1'b0; Branch_Taken = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ea = WRAP_PC + 32'(4 * i);
            checks++;
            if ({w_req, w_addr} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL wrap_fetch cyc %0d: got req=%b addr=%h, want 1 %h", i, w_req, w_addr, ea);
            end
            if (i >= 2) begin
                ea = WRAP_PC + 32'(4 * (i - 2));
                checks++;
                if ({w_valid, w_pc, w_instr} !== {1'b1, ea, memf(ea)}) begin
                    errors++;
                    $display("FAIL wrap_head cyc %0d: got v=%b pc=%h ins=%h, want 1 %h %h",
                             i, w_valid, w_pc, w_instr, ea, memf(ea));
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_main cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_freeze_fill();
        test_branch_flush();
        test_branch_pop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
